washer_pickup_seq: RTL and testbench

WASHER_PICKUP_SEQ -- requirements
Module: washer_pickup_seq

---
 rtl/washer_pickup_seq.sv | 170 +++++++++++++++++
 tb/tb_washer_pickup_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/washer_pickup_seq.sv
// washer_pickup_seq: sequences one washer pickup. The magnet is lowered, grabs
// the washer, lifts it, carries it back, releases it, returns to the front and
// lowers the lift again. Every wait state has a watchdog, and an abort input
// returns the sequencer to IDLE from any state.
//
// Ports
//   CLK, reset           clock (rising edge) and async active-low reset
//   start, abort         request one pickup cycle / return to IDLE
//   done_*               level done flags from the subsystems
//   enable_*, start_magnet, pullup_procedure, go_back   subsystem commands
//   busy, done, err, err_state, state                   status (all registered)
module washer_pickup_seq #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000,
    parameter logic [23:0] SETTLE_CYCLES  = 24'd500000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       done_magnet_servo,
    input  logic       done_up,
    input  logic       done_down,
    input  logic       done_back,
    input  logic       done_front,
    output logic       enable_magnet_servo,
    output logic       start_magnet,
    output logic       enable_pullup_servo,
    output logic       enable_frontback,
    output logic [2:0] pullup_procedure,
    output logic [2:0] go_back,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] err_state,
    output logic [3:0] state
);

    localparam int unsigned CNT_W   = 24;
    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 4'd0,
        S_LOWER   = 4'd1,
        S_GRAB    = 4'd2,
        S_UP      = 4'd3,
        S_BACK    = 4'd4,
        S_RELEASE = 4'd5,
        S_FRONT   = 4'd6,
        S_DOWN    = 4'd7,
        S_FINISH  = 4'd8,
        S_ERR     = 4'd9
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flag_sel;
    logic               flag_accepted;
    logic               timed_out;
    logic               settled;

    logic               ems_d, sm_d, epu_d, efb_d, busy_d, done_d, err_d;
    logic [2:0]         pp_d, gb_d;
    logic [STATE_W-1:0] err_state_d;

    assign timed_out = (cnt_q == TIMEOUT_CYCLES - 24'd1);
    assign settled   = (cnt_q == SETTLE_CYCLES - 24'd1);
    assign state     = state_q;

    // State, dwell counter and registered outputs
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q             <= S_IDLE;
            cnt_q               <= '0;
            enable_magnet_servo <= 1'b0;
            start_magnet        <= 1'b0;
            enable_pullup_servo <= 1'b0;
            enable_frontback    <= 1'b0;
            pullup_procedure    <= 3'd0;
            go_back             <= 3'd0;
            busy                <= 1'b0;
            done                <= 1'b0;
            err                 <= 1'b0;
            err_state           <= '0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            enable_magnet_servo <= ems_d;
            start_magnet        <= sm_d;
            enable_pullup_servo <= epu_d;
            enable_frontback    <= efb_d;
            pullup_procedure    <= pp_d;
            go_back             <= gb_d;
            busy                <= busy_d;
            done                <= done_d;
            err                 <= err_d;
            err_state           <= err_state_d;
        end
    end

    // Next state, counter and output decode of the upcoming state
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        flag_sel      = 1'b0;
        flag_accepted = 1'b0;
        ems_d         = 1'b0;
        sm_d          = 1'b0;
        epu_d         = 1'b0;
        efb_d         = 1'b0;
        pp_d          = 3'd0;
        gb_d          = 3'd0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        err_d         = err;
        err_state_d   = err_state;

        case (state_q)
            S_LOWER: flag_sel = done_magnet_servo;
            S_UP:    flag_sel = done_up;
            S_BACK:  flag_sel = done_back;
            S_FRONT: flag_sel = done_front;
            S_DOWN:  flag_sel = done_down;
            default: flag_sel = 1'b0;
        endcase
        // First cycle of a wait state ignores levels left from the prior state
        flag_accepted = flag_sel && (cnt_q != '0);

        case (state_q)
            S_IDLE:    if (start) state_d = S_LOWER;
            S_LOWER:   if (flag_accepted) state_d = S_GRAB;    else if (timed_out) state_d = S_ERR;
            S_GRAB:    if (settled)       state_d = S_UP;
            S_UP:      if (flag_accepted) state_d = S_BACK;    else if (timed_out) state_d = S_ERR;
            S_BACK:    if (flag_accepted) state_d = S_RELEASE; else if (timed_out) state_d = S_ERR;
            S_RELEASE: if (settled)       state_d = S_FRONT;
            S_FRONT:   if (flag_accepted) state_d = S_DOWN;    else if (timed_out) state_d = S_ERR;
            S_DOWN:    if (flag_accepted) state_d = S_FINISH;  else if (timed_out) state_d = S_ERR;
            S_FINISH:  state_d = S_IDLE;
            S_ERR:     state_d = S_ERR;
            default:   state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;

        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q != S_IDLE && state_q != S_ERR)
            cnt_d = cnt_q + 24'd1;

        // Error flag latches the timed-out state; only a return to IDLE clears it
        if (state_d == S_ERR && state_q != S_ERR) begin
            err_d       = 1'b1;
            err_state_d = state_q;
        end else if (state_d == S_IDLE) begin
            err_d       = 1'b0;
            err_state_d = '0;
        end

        case (state_d)
            S_LOWER:   ems_d = 1'b1;
            S_GRAB:    begin ems_d = 1'b1; sm_d = 1'b1; end
            S_UP:      begin sm_d = 1'b1; epu_d = 1'b1; pp_d = 3'd1; end
            S_BACK:    begin sm_d = 1'b1; efb_d = 1'b1; gb_d = 3'd1; end
            S_FRONT:   begin efb_d = 1'b1; gb_d = 3'd2; end
            S_DOWN:    begin epu_d = 1'b1; pp_d = 3'd2; end
            S_FINISH:  done_d = 1'b1;
            default:   ;
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_ERR);
    end

endmodule

// File: tb/tb_washer_pickup_seq.sv
module tb_washer_pickup_seq;

    localparam int T = 16;
    localparam int S = 4;

    logic       CLK;
    logic       reset;
    logic       start, abort;
    logic       done_magnet_servo, done_up, done_down, done_back, done_front;
    logic       enable_magnet_servo, start_magnet, enable_pullup_servo, enable_frontback;
    logic [2:0] pullup_procedure, go_back;
    logic       busy, done, err;
    logic [3:0] err_state, state;

    washer_pickup_seq #(
        .TIMEOUT_CYCLES(24'd16),
        .SETTLE_CYCLES (24'd4)
    ) dut (
        .CLK                (CLK),
        .reset              (reset),
        .start              (start),
        .abort              (abort),
        .done_magnet_servo  (done_magnet_servo),
        .done_up            (done_up),
        .done_down          (done_down),
        .done_back          (done_back),
        .done_front         (done_front),
        .enable_magnet_servo(enable_magnet_servo),
        .start_magnet       (start_magnet),
        .enable_pullup_servo(enable_pullup_servo),
        .enable_frontback   (enable_frontback),
        .pullup_procedure   (pullup_procedure),
        .go_back            (go_back),
        .busy               (busy),
        .done               (done),
        .err                (err),
        .err_state          (err_state),
        .state              (state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: state code, cycles spent in it, error status
    int m_state = 0;
    int m_cnt   = 0;
    int m_err   = 0;
    int m_err_state = 0;

    // Responder: cycle index within a wait state at which its flag goes high
    int raise_at [10];
    logic stale_hold = 1'b0;

    // DUT-observed statistics
    int n_done = 0;
    int grab_cyc = 0;
    int rel_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected command outputs per state: {ems, sm, epu, efb, pullup[2:0], go_back[2:0]}
    function automatic logic [9:0] cmd_of(input int s);
        case (s)
            1: return 10'b1000_000_000;
            2: return 10'b1100_000_000;
            3: return 10'b0110_001_000;
            4: return 10'b0101_000_001;
            6: return 10'b0001_000_010;
            7: return 10'b0010_010_000;
            default: return 10'b0;
        endcase
    endfunction

    function automatic logic watched_flag(input int s);
        case (s)
            1: return done_magnet_servo;
            3: return done_up;
            4: return done_back;
            6: return done_front;
            7: return done_down;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_wait(input int s);
        return (s == 1 || s == 3 || s == 4 || s == 6 || s == 7);
    endfunction

    // One clock of the pickup sequence: the chain 1..8 is linear
    task automatic model_step();
        int nxt;
        nxt = m_state;
        if (m_state == 0) begin
            if (start) nxt = 1;
        end else if (is_wait(m_state)) begin
            if (m_cnt >= 1 && watched_flag(m_state)) nxt = m_state + 1;
            else if (m_cnt == T - 1) nxt = 9;
        end else if (m_state == 2 || m_state == 5) begin
            if (m_cnt == S - 1) nxt = m_state + 1;
        end else if (m_state == 8) begin
            nxt = 0;
        end
        if (abort) nxt = 0;
        if (nxt == 9 && m_state != 9) begin
            m_err = 1;
            m_err_state = m_state;
        end
        if (nxt == 0) begin
            m_err = 0;
            m_err_state = 0;
        end
        if (nxt != m_state) m_cnt = 0;
        else if (m_state != 0 && m_state != 9) m_cnt++;
        m_state = nxt;
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_err = 0; m_err_state = 0;
    endtask

    task automatic compare_all();
        logic [9:0] e;
        e = cmd_of(m_state);
        check("state", 32'(state), 32'(m_state));
        check("enable_magnet_servo", 32'(enable_magnet_servo), 32'(e[9]));
        check("start_magnet", 32'(start_magnet), 32'(e[8]));
        check("enable_pullup_servo", 32'(enable_pullup_servo), 32'(e[7]));
        check("enable_frontback", 32'(enable_frontback), 32'(e[6]));
        check("pullup_procedure", 32'(pullup_procedure), 32'(e[5:3]));
        check("go_back", 32'(go_back), 32'(e[2:0]));
        check("busy", 32'(busy), 32'(m_state != 0 && m_state != 9));
        check("done", 32'(done), 32'(m_state == 8));
        check("err", 32'(err), 32'(m_err));
        check("err_state", 32'(err_state), 32'(m_err_state));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        compare_all();
        if (done === 1'b1) n_done++;
        if (state === 4'd2) grab_cyc++;
        if (state === 4'd5) rel_cyc++;
    endtask

    task automatic drive_resp();
        logic f;
        f = is_wait(m_state) && (m_cnt >= raise_at[m_state]);
        done_magnet_servo = (f && m_state == 1) || stale_hold;
        done_up    = f && m_state == 3;
        done_back  = f && m_state == 4;
        done_front = f && m_state == 6;
        done_down  = f && m_state == 7;
    endtask

    task automatic run_until(input int target, input int max_ticks, input string tag, output int ticks);
        ticks = 0;
        while (m_state != target && ticks < max_ticks) begin
            drive_resp();
            tick();
            ticks++;
        end
        check(tag, 32'(state), 32'(target));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        drive_resp();
        tick();
        start = 1'b0;
    endtask

    int nt;

    initial begin
        for (int i = 0; i < 10; i++) raise_at[i] = 3;
        start = 1'b0; abort = 1'b0;
        done_magnet_servo = 1'b0; done_up = 1'b0; done_down = 1'b0;
        done_back = 1'b0; done_front = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge CLK);
        compare_all();
        reset = 1'b1;
        repeat (2) tick();

        // Full cycle with flags raised three cycles into each wait state
        n_done = 0; grab_cyc = 0; rel_cyc = 0;
        pulse_start();
        check("full_enter_lower", 32'(state), 32'd1);
        run_until(0, 200, "full_return_idle", nt);
        check("full_done_pulses", 32'(n_done), 32'd1);
        check("grab_len", 32'(grab_cyc), 32'(S));
        check("release_len", 32'(rel_cyc), 32'(S));

        // Watchdog in UP, start ignored in ERR, abort clears
        raise_at[3] = 1000;
        pulse_start();
        run_until(3, 100, "timeout_reach_up", nt);
        run_until(9, 40, "timeout_reach_err", nt);
        check("timeout_latency", 32'(nt), 32'(T));
        check("timeout_err_state", 32'(err_state), 32'd3);
        check("timeout_err", 32'(err), 32'd1);
        start = 1'b1; drive_resp(); tick(); start = 1'b0;
        check("err_ignores_start", 32'(state), 32'd9);
        abort = 1'b1; drive_resp(); tick(); abort = 1'b0;
        check("abort_from_err", 32'(state), 32'd0);
        check("abort_clears_err", 32'(err), 32'd0);
        raise_at[3] = 3;

        // Stale done_magnet_servo held high before start
        stale_hold = 1'b1;
        drive_resp(); tick();
        pulse_start();
        drive_resp(); tick();
        check("stale_first_cycle", 32'(state), 32'd1);
        drive_resp(); tick();
        check("stale_second_cycle", 32'(state), 32'd2);
        stale_hold = 1'b0;
        run_until(0, 200, "stale_return_idle", nt);

        // Abort during FRONT
        n_done = 0;
        pulse_start();
        run_until(6, 200, "abort_reach_front", nt);
        abort = 1'b1; drive_resp(); tick(); abort = 1'b0;
        check("abort_front_state", 32'(state), 32'd0);
        check("abort_front_go_back", 32'(go_back), 32'd0);
        repeat (3) begin drive_resp(); tick(); end
        check("abort_no_done", 32'(n_done), 32'd0);

        // done_down arrives in the very timeout cycle
        raise_at[7] = T - 1;
        pulse_start();
        run_until(7, 200, "collision_reach_down", nt);
        run_until(8, 40, "collision_finish", nt);
        check("collision_latency", 32'(nt), 32'(T));
        drive_resp(); tick();
        raise_at[7] = 3;
        start = 1'b1; abort = 1'b1; drive_resp(); tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start_idle", 32'(state), 32'd0);

        // Asynchronous reset in the middle of UP
        pulse_start();
        run_until(3, 100, "reset_reach_up", nt);
        drive_resp(); tick();
        #2 reset = 1'b0;
        #1;
        check("reset_start_magnet", 32'(start_magnet), 32'd0);
        check("reset_pullup_servo", 32'(enable_pullup_servo), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        model_reset();
        drive_resp();
        @(negedge CLK);
        compare_all();
        reset = 1'b1;
        repeat (2) tick();

        // Randomized traffic, flag density varied per segment
        for (int seg = 0; seg < 15; seg++) begin
            int p;
            case ($urandom_range(2, 0))
                0: p = 2;
                1: p = 6;
                default: p = 30;
            endcase
            for (int c = 0; c < 200; c++) begin
                start = ($urandom_range(3, 0) == 0);
                abort = ($urandom_range(39, 0) == 0);
                done_magnet_servo = ($urandom_range(p - 1, 0) == 0);
                done_up    = ($urandom_range(p - 1, 0) == 0);
                done_down  = ($urandom_range(p - 1, 0) == 0);
                done_back  = ($urandom_range(p - 1, 0) == 0);
                done_front = ($urandom_range(p - 1, 0) == 0);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
